// File: rtl/up_io_ctrl_if.sv
// Bus, channel I/O and interrupt signals between the up core and up_io_ctrl.
// master = core/environment side, slave = the controller.
interface up_io_ctrl_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 8,
    parameter int VEC_W    = 2
);
    logic [ADDR_W-1:0]          bus_addr;
    logic                       bus_wr;
    logic                       bus_rd;
    logic [DATA_W-1:0]          bus_wdata;
    logic [DATA_W-1:0]          bus_rdata;
    logic [CHANNELS*DATA_W-1:0] io_in;
    logic [CHANNELS-1:0]        io_load;
    logic [CHANNELS*DATA_W-1:0] io_out;
    logic                       irq_n;
    logic [VEC_W-1:0]           irq_vec;
    logic                       irq_ack;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wdata, io_in, io_load, irq_ack,
        input  bus_rdata, io_out, irq_n, irq_vec
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wdata, io_in, io_load, irq_ack,
        output bus_rdata, io_out, irq_n, irq_vec
    );
endinterface

// File: rtl/up_io_ctrl.sv
// Memory-mapped multi-channel I/O and priority interrupt controller for the up core.
// Define UP_IO_CTRL_SYNC_EN to add a two-flop synchroniser on each io_load bit.
module up_io_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                CHANNELS  = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
    parameter int                VEC_W     = 2
) (
    input logic           clk,
    input logic           rst,
    up_io_ctrl_if.slave   bus
);

    localparam logic [ADDR_W-1:0] OFF_PEND = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(CHANNELS + 1);

    logic [CHANNELS-1:0][DATA_W-1:0] r_out;
    logic [CHANNELS-1:0][DATA_W-1:0] r_in;
    logic [CHANNELS-1:0]             r_pend;
    logic [CHANNELS-1:0]             r_mask;
    logic [CHANNELS-1:0]             r_load_d;
    logic [DATA_W-1:0]               r_rdata;
    logic                            r_irq_n;
    logic [VEC_W-1:0]                r_irq_vec;

    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] w_active;
    logic [CHANNELS-1:0] w_pend_next;
    logic [ADDR_W-1:0]   w_off;
    logic                w_in_win;
    logic [DATA_W-1:0]   w_rd_val;
    logic [VEC_W-1:0]    w_first;

`ifdef UP_IO_CTRL_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.io_load;
            r_sync2 <= r_sync1;
        end
    end

    assign w_load = r_sync2;
`else
    assign w_load = bus.io_load;
`endif

    // Edge flop resets to 0, so a strobe already high at reset release counts once.
    assign w_rise   = w_load & ~r_load_d;
    assign w_off    = bus.bus_addr - BASE_ADDR;
    assign w_in_win = (bus.bus_addr >= BASE_ADDR) && (w_off <= OFF_MASK);
    assign w_active = r_pend & r_mask;

    always_comb begin
        w_rd_val = '0;
        if (w_in_win) begin
            if (w_off == OFF_PEND) begin
                w_rd_val = DATA_W'(r_pend);
            end else if (w_off == OFF_MASK) begin
                w_rd_val = DATA_W'(r_mask);
            end else begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (w_off == ADDR_W'(k)) w_rd_val = r_in[k];
                end
            end
        end
    end

    // Lowest active index wins; vector holds when nothing is active.
    always_comb begin
        w_first = r_irq_vec;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_active[k]) w_first = VEC_W'(k);
        end
    end

    always_comb begin
        w_clr = '0;
        if (bus.bus_wr && w_in_win && (w_off == OFF_PEND)) begin
            w_clr = bus.bus_wdata[CHANNELS-1:0];
        end
        if (bus.irq_ack && !r_irq_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (r_irq_vec == VEC_W'(k)) w_clr[k] = 1'b1;
            end
        end
    end

    // A new edge overrides a simultaneous clear so no event is dropped.
    assign w_pend_next = (r_pend & ~w_clr) | w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_in      <= '0;
            r_pend    <= '0;
            r_mask    <= '0;
            r_load_d  <= '0;
            r_rdata   <= '0;
            r_irq_n   <= 1'b1;
            r_irq_vec <= '0;
        end else begin
            r_load_d  <= w_load;
            r_pend    <= w_pend_next;
            r_irq_n   <= ~|w_active;
            r_irq_vec <= w_first;
            if (bus.bus_rd) r_rdata <= w_rd_val;
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_rise[k]) r_in[k] <= bus.io_in[k*DATA_W +: DATA_W];
            end
            if (bus.bus_wr && w_in_win) begin
                if (w_off == OFF_MASK) r_mask <= bus.bus_wdata[CHANNELS-1:0];
                for (int k = 0; k < CHANNELS; k++) begin
                    if (w_off == ADDR_W'(k)) r_out[k] <= bus.bus_wdata;
                end
            end
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign bus.io_out    = r_out;
    assign bus.irq_n     = r_irq_n;
    assign bus.irq_vec   = r_irq_vec;

endmodule
